// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared types and constants for the instruction fetch stage
package instr_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_DISCARD = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] PC_READ_OFFSET   = 32'd8;

   localparam int COND_LSB  = 28;
   localparam int COND_W    = 4;
   localparam int OP_LSB    = 26;
   localparam int OP_W      = 2;
   localparam int FUNCT_LSB = 20;
   localparam int FUNCT_W   = 6;
   localparam int RD_LSB    = 12;
   localparam int RD_W      = 4;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory and decoder-facing signals of the fetch stage
interface instr_fetch_if;
   import instr_fetch_pkg::*;

   logic                 imem_req;
   logic [31:0]          imem_addr;
   logic                 imem_ack;
   logic [31:0]          imem_rdata;
   logic                 redirect;
   logic [31:0]          redirect_pc;
   logic                 instr_valid;
   logic                 instr_ready;
   logic [31:0]          instr;
   logic [31:0]          instr_pc;
   logic [31:0]          pc_plus8;
   logic [COND_W-1:0]    cond;
   logic [OP_W-1:0]      op;
   logic [FUNCT_W-1:0]   funct;
   logic [RD_W-1:0]      rd;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      input  redirect, redirect_pc,
      output instr_valid,
      input  instr_ready,
      output instr, instr_pc, pc_plus8, cond, op, funct, rd
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      output redirect, redirect_pc,
      input  instr_valid,
      output instr_ready,
      input  instr, instr_pc, pc_plus8, cond, op, funct, rd
   );

endinterface

// File: rtl/instr_fetch_fifo.sv
// rtl/instr_fetch_fifo.sv - synchronous FIFO of fetched {instr, pc} entries
module fetch_fifo
   import instr_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  fetch_entry_t             push_data,
   input  logic                     pop,
   input  logic                     flush,
   output fetch_entry_t             head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   // Flush wins over any same-cycle push or pop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch PC, single-outstanding imem requests, buffered decoder feed
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          DEPTH    = 2
) (
   input  logic           clk,
   input  logic           reset,
   instr_fetch_if.master  bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t    state_q, state_d;
   logic [31:0]     fpc_q, fpc_d;
   logic [31:0]     disc_addr_q, disc_addr_d;
   logic            push, pop, flush;
   logic            full, empty;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_after_push;
   fetch_entry_t    push_entry;
   fetch_entry_t    head;

   assign pop              = ~empty & bus.instr_ready & ~bus.redirect;
   assign push_entry       = '{instr: bus.imem_rdata, pc: fpc_q};
   assign count_after_push = count + CW'(1) - CW'(pop);

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (flush),
      .head      (head),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         fpc_q       <= RESET_PC;
         disc_addr_q <= RESET_PC;
      end else begin
         state_q     <= state_d;
         fpc_q       <= fpc_d;
         disc_addr_q <= disc_addr_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      fpc_d         = fpc_q;
      disc_addr_d   = disc_addr_q;
      push          = 1'b0;
      flush         = 1'b0;
      bus.imem_req  = 1'b0;
      bus.imem_addr = fpc_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.redirect) begin
               flush   = 1'b1;
               fpc_d   = word_align(bus.redirect_pc);
               state_d = ST_REQ;
            end else if (!full) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            bus.imem_req = 1'b1;
            if (bus.redirect) begin
               // Without an ack the old request is still in flight; keep its address.
               flush       = 1'b1;
               fpc_d       = word_align(bus.redirect_pc);
               disc_addr_d = fpc_q;
               state_d     = bus.imem_ack ? ST_REQ : ST_DISCARD;
            end else if (bus.imem_ack) begin
               push    = 1'b1;
               fpc_d   = fpc_q + 32'd4;
               state_d = (count_after_push < CW'(DEPTH)) ? ST_REQ : ST_IDLE;
            end
         end
         ST_DISCARD: begin
            bus.imem_req  = 1'b1;
            bus.imem_addr = disc_addr_q;
            if (bus.redirect) begin
               flush = 1'b1;
               fpc_d = word_align(bus.redirect_pc);
            end
            if (bus.imem_ack) begin
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.instr_valid = ~empty;
   assign bus.instr       = head.instr;
   assign bus.instr_pc    = head.pc;
   assign bus.pc_plus8    = head.pc + PC_READ_OFFSET;
   assign bus.cond        = head.instr[COND_LSB +: COND_W];
   assign bus.op          = head.instr[OP_LSB +: OP_W];
   assign bus.funct       = head.instr[FUNCT_LSB +: FUNCT_W];
   assign bus.rd          = head.instr[RD_LSB +: RD_W];

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;
   import instr_fetch_pkg::*;

   localparam int DEPTH = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   instr_fetch_if bus();

   instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } sb_t;

   typedef struct {
      logic [31:0] word;
      logic [3:0]  cond;
      logic [1:0]  op;
      logic [5:0]  funct;
      logic [3:0]  rd;
   } fvec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   sb_t         sbq[$];
   logic [31:0] exp_pc;
   logic [31:0] disc_addr;
   logic        drop_next;
   logic        force_en;
   logic [31:0] force_word;
   fvec_t       fv[4];
   int          nvalid;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (force_en) return force_word;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a falling edge: compare, drive the next cycle's inputs, update the model.
   task automatic step(input logic ack_en, input logic rdy, input logic redir, input logic [31:0] rpc);
      logic ack;
      logic popped;
      chk("instr_valid", bus.instr_valid, sbq.size() != 0);
      if (bus.instr_valid && sbq.size() != 0) begin
         chk("instr", bus.instr, sbq[0].instr);
         chk("instr_pc", bus.instr_pc, sbq[0].pc);
         chk("pc_plus8", bus.pc_plus8, sbq[0].pc + 32'd8);
         chk("cond", bus.cond, sbq[0].instr[31:28]);
         chk("op", bus.op, sbq[0].instr[27:26]);
         chk("funct", bus.funct, sbq[0].instr[25:20]);
         chk("rd", bus.rd, sbq[0].instr[15:12]);
      end
      if (bus.imem_req) begin
         chk("req_has_space", sbq.size() < DEPTH, 1);
         chk("imem_addr", bus.imem_addr, drop_next ? disc_addr : exp_pc);
      end
      ack    = ack_en & bus.imem_req;
      popped = bus.instr_valid & rdy & ~redir;
      bus.imem_ack    = ack;
      bus.imem_rdata  = mem_word(bus.imem_addr);
      bus.instr_ready = rdy;
      bus.redirect    = redir;
      bus.redirect_pc = rpc;
      if (redir) begin
         if (ack) begin
            drop_next = 1'b0;
         end else if (bus.imem_req && !drop_next) begin
            drop_next = 1'b1;
            disc_addr = exp_pc;
         end
         exp_pc = {rpc[31:2], 2'b00};
         sbq.delete();
      end else begin
         if (popped && sbq.size() != 0) void'(sbq.pop_front());
         if (ack) begin
            if (drop_next) begin
               drop_next = 1'b0;
            end else begin
               sbq.push_back('{mem_word(exp_pc), exp_pc});
               exp_pc = exp_pc + 32'd4;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset          = 1'b0;
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
      #1;
      chk("rst_imem_req", bus.imem_req, 0);
      chk("rst_imem_addr", bus.imem_addr, 32'h0);
      chk("rst_instr_valid", bus.instr_valid, 0);
      chk("rst_instr", bus.instr, 32'h0);
      chk("rst_instr_pc", bus.instr_pc, 32'h0);
      chk("rst_pc_plus8", bus.pc_plus8, 32'h8);
      chk("rst_fields", {bus.cond, bus.op, bus.funct, bus.rd}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      chk("rst_ack_ignored", bus.instr_valid, 0);
      bus.imem_ack = 1'b0;
      reset        = 1'b1;
      sbq.delete();
      exp_pc    = 32'h0;
      disc_addr = 32'h0;
      drop_next = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      fv[0] = '{32'hE081_2003, 4'hE, 2'd0, 6'b001000, 4'h2};
      fv[1] = '{32'h1A2B_3C4D, 4'h1, 2'd2, 6'b100010, 4'h3};
      fv[2] = '{32'hFFFF_FFFF, 4'hF, 2'd3, 6'b111111, 4'hF};
      fv[3] = '{32'h5DF0_A000, 4'h5, 2'd3, 6'b011111, 4'hA};

      force_en        = 1'b0;
      force_word      = 32'h0;
      bus.imem_ack    = 1'b0;
      bus.imem_rdata  = 32'h0;
      bus.instr_ready = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;

      do_reset();

      // Streaming: one instruction per cycle once the pipe fills.
      nvalid = 0;
      for (int i = 0; i < 14; i++) begin
         if (i >= 4 && bus.instr_valid) nvalid++;
         step(1'b1, 1'b1, 1'b0, 32'h0);
      end
      chk("throughput", nvalid, 10);

      // Back-pressure, with reset hitting an active stream.
      do_reset();
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("full_req_low", bus.imem_req, 0);
      chk("full_head_pc", bus.instr_pc, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("no_req_same_cycle_as_pop", bus.imem_req, 0);
      for (int k = 0; k < 4; k++) begin
         if (bus.imem_req) break;
         step(1'b0, 1'b0, 1'b0, 32'h0);
      end
      chk("req_reassert", bus.imem_req, 1);
      chk("req_addr8", bus.imem_addr, 32'h8);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

      // Redirect while the ack is delayed.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         if (bus.imem_req) break;
         step(1'b0, 1'b1, 1'b0, 32'h0);
      end
      chk("wait_req", bus.imem_req, 1);
      step(1'b0, 1'b1, 1'b1, 32'h100);
      chk("discard_req", bus.imem_req, 1);
      chk("discard_old_addr", bus.imem_addr, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("dropped_not_valid", bus.instr_valid, 0);
      chk("new_req_addr", bus.imem_addr, 32'h100);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("first_new_valid", bus.instr_valid, 1);
      chk("first_new_pc", bus.instr_pc, 32'h100);

      // Redirect coincident with ack and pop.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("pre_redirect_valid", bus.instr_valid, 1);
      step(1'b1, 1'b1, 1'b1, 32'h203);
      chk("flush_valid", bus.instr_valid, 0);
      chk("flush_req", bus.imem_req, 1);
      chk("flush_addr", bus.imem_addr, 32'h200);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

      // PC wrap at the top of the address space.
      step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("wrap_pc0", bus.instr_pc, 32'hFFFF_FFFC);
      chk("wrap_plus8_0", bus.pc_plus8, 32'h4);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("wrap_pc1", bus.instr_pc, 32'h0);
      chk("wrap_plus8_1", bus.pc_plus8, 32'h8);

      // Field slicing vectors.
      force_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         force_word = fv[i].word;
         step(1'b0, 1'b0, 1'b1, 32'h400 + 32'(i * 16));
         for (int k = 0; k < 6; k++) begin
            if (bus.instr_valid) break;
            step(1'b1, 1'b0, 1'b0, 32'h0);
         end
         chk("vec_valid", bus.instr_valid, 1);
         chk("vec_cond", bus.cond, fv[i].cond);
         chk("vec_op", bus.op, fv[i].op);
         chk("vec_funct", bus.funct, fv[i].funct);
         chk("vec_rd", bus.rd, fv[i].rd);
      end
      force_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
